// File: rtl/traffic_pkg.sv
// Shared encodings for the N-way traffic light: phase codes, FSM states, per-road light patterns.
package traffic_pkg;

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALLRED = 2'd2;
  localparam logic [1:0] PH_FLASH  = 2'd3;

  // State codes double as the externally visible phase value.
  typedef enum logic [1:0] {
    ST_GREEN  = PH_GREEN,
    ST_YELLOW = PH_YELLOW,
    ST_ALLRED = PH_ALLRED,
    ST_FLASH  = PH_FLASH
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  function automatic int timer_width(int a, int b, int c, int d);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin pick: first requesting road after cur (cur itself last),
// falling back to cur+1 when nobody is asking.
module tl_rr_pick #(
  parameter int N_ROADS = 4
) (
  input  logic [N_ROADS-1:0]         req,
  input  logic [$clog2(N_ROADS)-1:0] cur,
  output logic [$clog2(N_ROADS)-1:0] nxt
);

  localparam int RW = $clog2(N_ROADS);

  logic [RW-1:0] idx;
  logic          found;

  always_comb begin
    nxt   = (cur == RW'(N_ROADS - 1)) ? '0 : cur + RW'(1);
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_ROADS; i++) begin
      idx = RW'((int'(cur) + i) % N_ROADS);
      if (!found && req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_nway.sv
// N-way traffic light controller: GREEN/YELLOW/ALLRED rotation with demand-driven road pick,
// plus a flashing-yellow mode; all outputs are Moore decodes of registered state.
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter int N_ROADS  = 4,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_FLASH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       switch,
  input  logic [N_ROADS-1:0]         req,
  output logic [3*N_ROADS-1:0]       lights,
  output logic [$clog2(N_ROADS)-1:0] active_road,
  output logic [1:0]                 phase
);

  localparam int RW = $clog2(N_ROADS);
  localparam int TW = timer_width(T_GREEN, T_YELLOW, T_ALLRED, T_FLASH);

  state_t        state_q, state_d;
  logic [RW-1:0] road_q, road_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          toggle_q, toggle_d;
  logic [RW-1:0] rr_next;

  tl_rr_pick #(.N_ROADS(N_ROADS)) u_rr_pick (
    .req (req),
    .cur (road_q),
    .nxt (rr_next)
  );

  always_comb begin
    state_d  = state_q;
    road_d   = road_q;
    toggle_d = toggle_q;
    timer_d  = (timer_q == '0) ? '0 : timer_q - TW'(1);
    if (!switch && state_q != ST_FLASH) begin
      state_d  = ST_FLASH;
      toggle_d = 1'b1;
      timer_d  = TW'(T_FLASH - 1);
    end else begin
      case (state_q)
        ST_GREEN: if (timer_q == '0) begin
          state_d = ST_YELLOW;
          timer_d = TW'(T_YELLOW - 1);
        end
        ST_YELLOW: if (timer_q == '0) begin
          state_d = ST_ALLRED;
          timer_d = TW'(T_ALLRED - 1);
        end
        ST_ALLRED: if (timer_q == '0) begin
          state_d = ST_GREEN;
          road_d  = rr_next;
          timer_d = TW'(T_GREEN - 1);
        end
        ST_FLASH: begin
          // Leaving flash parks on the last road so the first green goes through the pick.
          if (switch) begin
            state_d = ST_ALLRED;
            road_d  = RW'(N_ROADS - 1);
            timer_d = TW'(T_ALLRED - 1);
          end else if (timer_q == '0) begin
            toggle_d = ~toggle_q;
            timer_d  = TW'(T_FLASH - 1);
          end
        end
        default: begin
          state_d = ST_ALLRED;
          timer_d = TW'(T_ALLRED - 1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ALLRED;
      road_q   <= RW'(N_ROADS - 1);
      timer_q  <= TW'(T_ALLRED - 1);
      toggle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      road_q   <= road_d;
      timer_q  <= timer_d;
      toggle_q <= toggle_d;
    end
  end

  assign phase       = state_q;
  assign active_road = road_q;

  always_comb begin
    lights = '0;
    for (int k = 0; k < N_ROADS; k++) begin
      case (state_q)
        ST_GREEN:  lights[3*k +: 3] = (road_q == RW'(k)) ? GREEN : RED;
        ST_YELLOW: lights[3*k +: 3] = (road_q == RW'(k)) ? YELLOW : RED;
        ST_FLASH:  lights[3*k +: 3] = toggle_q ? YELLOW : OFF;
        default:   lights[3*k +: 3] = RED;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_nway.sv
// Bench for traffic_light_nway: phase-length model checked every cycle plus directed literal checks.
module tb_traffic_light_nway;

  localparam int N  = 4;
  localparam int TG = 8;
  localparam int TY = 3;
  localparam int TA = 2;
  localparam int TF = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sw  = 1'b1;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] lights;
  logic [1:0]     active_road;
  logic [1:0]     phase;

  int n_err = 0;
  int n_chk = 0;
  bit mon_en = 1'b0;

  traffic_light_nway #(
    .N_ROADS(N), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_FLASH(TF)
  ) dut (
    .clk(clk), .rst(rst), .switch(sw), .req(req),
    .lights(lights), .active_road(active_road), .phase(phase)
  );

  always #5 clk = ~clk;

  // Model state: phase code, served road, cycles elapsed in the phase, flash lamp on.
  typedef struct {
    int ph;
    int road;
    int el;
    bit tog;
  } mst_t;

  localparam mst_t M_RST = '{ph: 2, road: N - 1, el: 0, tog: 1'b1};
  mst_t m = M_RST;

  function automatic int plen(int ph);
    if (ph == 0) return TG;
    if (ph == 1) return TY;
    return TA;
  endfunction

  function automatic int pick(logic [N-1:0] r, int cur);
    for (int off = 1; off <= N; off++)
      if (r[(cur + off) % N]) return (cur + off) % N;
    return (cur + 1) % N;
  endfunction

  function automatic mst_t mstep(mst_t s, bit sw_i, logic [N-1:0] r);
    mst_t nx = s;
    if (!sw_i && s.ph != 3) begin
      nx.ph = 3; nx.el = 0; nx.tog = 1'b1;
    end else if (s.ph == 3) begin
      if (sw_i) begin
        nx.ph = 2; nx.road = N - 1; nx.el = 0;
      end else begin
        nx.el = s.el + 1;
        if (nx.el == TF) begin nx.el = 0; nx.tog = !s.tog; end
      end
    end else begin
      nx.el = s.el + 1;
      if (nx.el == plen(s.ph)) begin
        nx.el = 0;
        if (s.ph == 0) nx.ph = 1;
        else if (s.ph == 1) nx.ph = 2;
        else begin nx.ph = 0; nx.road = pick(r, s.road); end
      end
    end
    return nx;
  endfunction

  function automatic logic [3*N-1:0] exp_lights(mst_t s);
    logic [3*N-1:0] v = '0;
    for (int k = 0; k < N; k++) begin
      if (s.ph == 3)      v[3*k +: 3] = s.tog ? 3'b010 : 3'b000;
      else if (s.ph == 2) v[3*k +: 3] = 3'b100;
      else if (k == s.road) v[3*k +: 3] = (s.ph == 0) ? 3'b001 : 3'b010;
      else                v[3*k +: 3] = 3'b100;
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RST;
    else     m <= mstep(m, sw, req);
  end

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("model_phase", int'(phase), m.ph);
      check("model_lights", int'(lights), int'(exp_lights(m)));
      if (m.ph != 3) check("model_road", int'(active_road), m.road);
    end
  end

  task automatic hold(int ph, int road, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("hold_phase", int'(phase), ph);
      check("hold_road", int'(active_road), road);
    end
  endtask

  task automatic flash(bit on, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("flash_phase", int'(phase), 3);
      check("flash_lights", int'(lights), on ? 'h492 : 'h000);
    end
  endtask

  initial begin
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_phase", int'(phase), 2);
    check("reset_lights", int'(lights), 'h924);
    check("reset_road", int'(active_road), 3);

    // Idle rotation from reset release.
    @(posedge clk);
    #2 rst = 1'b0;
    hold(2, 3, TA);
    for (int r = 0; r < N; r++) begin
      hold(0, r, TG);
      hold(1, r, TY);
      hold(2, r, TA);
    end
    hold(0, 0, 1);
    check("rot_lights_r0_green", int'(lights), 'h921);

    // Road 3 demand skips roads 1 and 2.
    req = 4'b1000;
    hold(0, 0, TG - 1);
    hold(1, 0, TY);
    check("skip_lights_r0_yellow", int'(lights), 'h922);
    hold(2, 0, TA);
    hold(0, 3, 1);
    check("skip_lights_r3_green", int'(lights), 'h324);
    req = '0;
    hold(0, 3, TG - 1);
    hold(1, 3, TY);
    hold(2, 3, TA);
    hold(0, 0, 1);

    // Sole requester is re-served.
    req = 4'b0001;
    hold(0, 0, TG - 1);
    hold(1, 0, TY);
    hold(2, 0, TA);
    hold(0, 0, 1);
    check("reserve_lights_r0", int'(lights), 'h921);

    // Transient demand that is gone by the all-red exit changes nothing.
    req = 4'b0100;
    hold(0, 0, 3);
    req = '0;
    hold(0, 0, TG - 4);
    hold(1, 0, TY);
    hold(2, 0, 1);
    req = 4'b0100;
    hold(2, 0, 1);
    req = '0;
    hold(0, 1, 1);
    check("transient_lights_r1", int'(lights), 'h90C);

    // Flash mode entered mid-green, left mid-on-period.
    hold(0, 1, 2);
    sw = 1'b0;
    flash(1'b1, TF);
    flash(1'b0, TF);
    flash(1'b1, 2);
    sw = 1'b1;
    hold(2, 3, TA);
    hold(0, 0, 1);
    check("unflash_lights_r0", int'(lights), 'h921);

    // Asynchronous reset pulse between clock edges mid-yellow.
    hold(0, 0, TG - 1);
    hold(1, 0, 2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_phase", int'(phase), 2);
    check("async_rst_lights", int'(lights), 'h924);
    check("async_rst_road", int'(active_road), 3);
    #1 rst = 1'b0;
    hold(2, 3, 1);
    hold(0, 0, 1);
    check("post_rst_lights_r0", int'(lights), 'h921);

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
